// File: rtl/framebuffer_sched.sv
// Arbiter/controller for the single-read/single-write LCD framebuffer BRAM: refresh streaming, column writes, pixel RMW.
// Optional FRAMEBUFFER_SCHED_RR_EN: round-robin between column-write and pixel requesters (default: column write wins).
module framebuffer_sched #(
    parameter int NUM_COLS = 84,
    parameter int COL_BITS = 48,
    parameter int ADDR_W   = 7,
    parameter int Y_W      = 6
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_frame_start,
    output logic                o_frame_busy,
    output logic                o_frame_done,
    output logic [COL_BITS-1:0] o_col_data,
    output logic                o_col_valid,
    input  logic                i_col_ready,
    input  logic                i_cw_valid,
    input  logic [ADDR_W-1:0]   i_cw_addr,
    input  logic [COL_BITS-1:0] i_cw_data,
    output logic                o_cw_ready,
    input  logic                i_px_valid,
    input  logic [ADDR_W-1:0]   i_px_x,
    input  logic [Y_W-1:0]      i_px_y,
    input  logic [1:0]          i_px_op,
    output logic                o_px_ready,
    output logic                o_bram_rd_en,
    output logic                o_bram_wr_en,
    output logic [ADDR_W-1:0]   o_bram_rd_addr,
    output logic [ADDR_W-1:0]   o_bram_wr_addr,
    output logic [COL_BITS-1:0] o_bram_wdata,
    input  logic [COL_BITS-1:0] i_bram_rdata,
    input  logic                i_bram_rvalid
);
    typedef enum logic [2:0] {S_IDLE, S_REF_WAIT, S_PX_WAIT, S_PX_WR, S_PX_ACK} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_ref_col;
    logic                r_frame_busy, r_frame_done, r_col_valid;
    logic [COL_BITS-1:0] r_col_data, r_px_col;
    logic [ADDR_W-1:0]   r_px_x;
    logic [Y_W-1:0]      r_px_y;
    logic [1:0]          r_px_op;
`ifdef FRAMEBUFFER_SCHED_RR_EN
    logic                r_last_px;
`endif

    logic                w_cw_inrange, w_px_inrange, w_ref_req;
    logic                w_gnt_ref, w_gnt_cw, w_gnt_px;
    logic [COL_BITS-1:0] w_px_mask, w_px_mod;

    assign w_cw_inrange = {1'b0, i_cw_addr} < (ADDR_W+1)'(NUM_COLS);
    assign w_px_inrange = ({1'b0, i_px_x} < (ADDR_W+1)'(NUM_COLS)) &&
                          ({1'b0, i_px_y} < (Y_W+1)'(COL_BITS));
    assign w_ref_req    = r_frame_busy & ~r_col_valid;

    // One grant per cycle, only from IDLE; refresh always outranks the host ports.
    always_comb begin
        w_gnt_ref = 1'b0;
        w_gnt_cw  = 1'b0;
        w_gnt_px  = 1'b0;
        if (!i_reset && r_state == S_IDLE) begin
            if (w_ref_req)
                w_gnt_ref = 1'b1;
`ifdef FRAMEBUFFER_SCHED_RR_EN
            else if (i_cw_valid && i_px_valid) begin
                if (r_last_px) w_gnt_cw = 1'b1;
                else           w_gnt_px = 1'b1;
            end
`endif
            else if (i_cw_valid)
                w_gnt_cw = 1'b1;
            else if (i_px_valid)
                w_gnt_px = 1'b1;
        end
    end

    always_comb begin
        w_px_mask = COL_BITS'(1) << r_px_y;
        case (r_px_op)
            2'b00:   w_px_mod = i_bram_rdata & ~w_px_mask;
            2'b01:   w_px_mod = i_bram_rdata |  w_px_mask;
            2'b10:   w_px_mod = i_bram_rdata ^  w_px_mask;
            default: w_px_mod = i_bram_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_ref)      w_next = S_REF_WAIT;
                else if (w_gnt_px)  w_next = w_px_inrange ? S_PX_WAIT : S_PX_ACK;
            end
            S_REF_WAIT: if (i_bram_rvalid) w_next = S_IDLE;
            S_PX_WAIT:  if (i_bram_rvalid) w_next = S_PX_WR;
            S_PX_WR:    w_next = S_IDLE;
            S_PX_ACK:   w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // BRAM strobes and grants are pure decodes; held low while reset is asserted.
    always_comb begin
        o_bram_rd_en   = 1'b0;
        o_bram_wr_en   = 1'b0;
        o_bram_rd_addr = '0;
        o_bram_wr_addr = '0;
        o_bram_wdata   = '0;
        o_cw_ready     = 1'b0;
        o_px_ready     = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_ref) begin
                        o_bram_rd_en   = 1'b1;
                        o_bram_rd_addr = r_ref_col;
                    end else if (w_gnt_cw) begin
                        o_cw_ready     = 1'b1;
                        o_bram_wr_en   = w_cw_inrange;
                        o_bram_wr_addr = w_cw_inrange ? i_cw_addr : '0;
                        o_bram_wdata   = w_cw_inrange ? i_cw_data : '0;
                    end else if (w_gnt_px && w_px_inrange) begin
                        o_bram_rd_en   = 1'b1;
                        o_bram_rd_addr = i_px_x;
                    end
                end
                S_PX_WR: begin
                    o_bram_wr_en   = 1'b1;
                    o_bram_wr_addr = r_px_x;
                    o_bram_wdata   = r_px_col;
                    o_px_ready     = 1'b1;
                end
                S_PX_ACK: o_px_ready = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ref_col    <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
            r_col_valid  <= 1'b0;
            r_col_data   <= '0;
            r_px_col     <= '0;
            r_px_x       <= '0;
            r_px_y       <= '0;
            r_px_op      <= '0;
`ifdef FRAMEBUFFER_SCHED_RR_EN
            r_last_px    <= 1'b1;
`endif
        end else begin
            r_frame_done <= 1'b0;
            if (i_frame_start && !r_frame_busy) begin
                r_frame_busy <= 1'b1;
                r_ref_col    <= '0;
            end
            if (r_col_valid && i_col_ready)
                r_col_valid <= 1'b0;
            if (w_gnt_px) begin
                r_px_x  <= i_px_x;
                r_px_y  <= i_px_y;
                r_px_op <= i_px_op;
            end
`ifdef FRAMEBUFFER_SCHED_RR_EN
            if (w_gnt_cw)      r_last_px <= 1'b0;
            else if (w_gnt_px) r_last_px <= 1'b1;
`endif
            if (r_state == S_REF_WAIT && i_bram_rvalid) begin
                r_col_data  <= i_bram_rdata;
                r_col_valid <= 1'b1;
                r_ref_col   <= r_ref_col + ADDR_W'(1);
                if (r_ref_col == ADDR_W'(NUM_COLS - 1)) begin
                    r_frame_busy <= 1'b0;
                    r_frame_done <= 1'b1;
                end
            end
            if (r_state == S_PX_WAIT && i_bram_rvalid)
                r_px_col <= w_px_mod;
        end
    end

    assign o_frame_busy = r_frame_busy;
    assign o_frame_done = r_frame_done;
    assign o_col_data   = r_col_data;
    assign o_col_valid  = r_col_valid;
endmodule

// File: tb/tb_framebuffer_sched.sv
// Directed bench for framebuffer_sched with a behavioural BRAM and a column scoreboard.
module tb_framebuffer_sched;
    localparam int NC = 84;

    logic        clk = 1'b0;
    logic        reset, frame_start, col_ready;
    logic        frame_busy, frame_done, col_valid, cw_ready, px_ready;
    logic [47:0] col_data, cw_data, bram_wdata, bram_rdata;
    logic        cw_valid, px_valid;
    logic [6:0]  cw_addr, px_x, bram_rd_addr, bram_wr_addr;
    logic [5:0]  px_y;
    logic [1:0]  px_op;
    logic        bram_rd_en, bram_wr_en, bram_rvalid;

    logic [47:0] mem     [0:NC-1];
    logic [47:0] exp_mem [0:NC-1];
    logic [47:0] exp_q[$];
    logic        preload;
    int n_cmp = 0, n_bad = 0, n_rd = 0, n_wr = 0, n_done = 0;

    always #5 clk = ~clk;

    framebuffer_sched dut (
        .i_clk(clk), .i_reset(reset), .i_frame_start(frame_start),
        .o_frame_busy(frame_busy), .o_frame_done(frame_done),
        .o_col_data(col_data), .o_col_valid(col_valid), .i_col_ready(col_ready),
        .i_cw_valid(cw_valid), .i_cw_addr(cw_addr), .i_cw_data(cw_data), .o_cw_ready(cw_ready),
        .i_px_valid(px_valid), .i_px_x(px_x), .i_px_y(px_y), .i_px_op(px_op), .o_px_ready(px_ready),
        .o_bram_rd_en(bram_rd_en), .o_bram_wr_en(bram_wr_en),
        .o_bram_rd_addr(bram_rd_addr), .o_bram_wr_addr(bram_wr_addr),
        .o_bram_wdata(bram_wdata), .i_bram_rdata(bram_rdata), .i_bram_rvalid(bram_rvalid)
    );

    // BRAM: 1-cycle read latency with valid strobe.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NC; i++) mem[i] <= 48'(i);
        end else if (bram_wr_en && bram_wr_addr < 7'(NC)) begin
            mem[bram_wr_addr] <= bram_wdata;
        end
        bram_rvalid <= bram_rd_en;
        bram_rdata  <= (bram_rd_addr < 7'(NC)) ? mem[bram_rd_addr] : 48'h0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard pops, read/write/done counters, read-to-valid latency.
    logic cv_prev = 1'b0, rd_h1 = 1'b0, rd_h2 = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (col_valid && !cv_prev) chk("col_valid_latency", 64'(rd_h2), 64'd1);
            if (col_valid && col_ready) begin
                if (exp_q.size() == 0) chk("col_unexpected", 64'(col_data), 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("col_data", 64'(col_data), 64'(exp_q.pop_front()));
            end
            if (frame_done) begin
                n_done++;
                chk("done_last_col", 64'(col_data), 64'd83);
            end
            if (bram_rd_en) n_rd++;
            if (bram_wr_en) n_wr++;
        end
        cv_prev = col_valid;
        rd_h2 = rd_h1;
        rd_h1 = bram_rd_en;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_px(input int budget, output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (cyc < budget) begin
            tick(); cyc++;
            if (px_ready) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_frame(input string tag);
        int c = 0;
        while (frame_busy && c < 400) begin tick(); c++; end
        chk({tag, "_frame_timeout"}, 64'(frame_busy), 64'd0);
        tick(); tick();
    endtask

    task automatic push_frame();
        for (int i = 0; i < NC; i++) exp_q.push_back(exp_mem[i]);
    endtask

    task automatic px_op_do(input logic [6:0] x, input logic [5:0] y, input logic [1:0] op,
                            input int lat, input string tag);
        int cyc; bit ok;
        px_valid = 1'b1; px_x = x; px_y = y; px_op = op;
        wait_px(6, cyc, ok);
        chk({tag, "_ready"}, 64'(ok), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        px_valid = 1'b0;
        tick();
    endtask

    initial begin
        int cyc, cw_n, px_n, rd0, wr0, bad;
        bit ok;
        reset = 1'b1; preload = 1'b1; frame_start = 0; col_ready = 0;
        cw_valid = 0; cw_addr = 0; cw_data = 0;
        px_valid = 0; px_x = 0; px_y = 0; px_op = 0;
        for (int i = 0; i < NC; i++) exp_mem[i] = 48'(i);
        tick(); preload = 1'b0; tick();
        reset = 1'b0; tick();
        chk("rst_col_valid", 64'(col_valid), 64'd0);
        chk("rst_frame_busy", 64'(frame_busy), 64'd0);
        chk("rst_bram_en", 64'({bram_rd_en, bram_wr_en, cw_ready, px_ready, frame_done}), 64'd0);
        chk("rst_col_data", 64'(col_data), 64'd0);

        // Full frame refresh, driver always ready.
        col_ready = 1'b1;
        push_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        chk("frame_busy_set", 64'(frame_busy), 64'd1);
        run_frame("f1");
        chk("f1_done_count", 64'(n_done), 64'd1);
        chk("f1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Column write then pixel RMW on column 5.
        cw_valid = 1'b1; cw_addr = 7'd5; cw_data = 48'h0; #1;
        chk("cw_ready", 64'(cw_ready), 64'd1);
        chk("cw_wr_en", 64'(bram_wr_en), 64'd1);
        tick(); cw_valid = 1'b0; exp_mem[5] = 48'h0;
        chk("cw_mem5", 64'(mem[5]), 64'd0);
        px_valid = 1'b1; px_x = 7'd5; px_y = 6'd47; px_op = 2'b01; #1;
        chk("px_rd_addr", 64'({bram_rd_en, bram_rd_addr}), 64'({1'b1, 7'd5}));
        wait_px(6, cyc, ok);
        chk("px_set_latency", 64'(cyc), 64'd2);
        chk("px_set_wdata", 64'({bram_wr_en, bram_wr_addr, bram_wdata}), 64'({1'b1, 7'd5, 48'h8000_0000_0000}));
        px_valid = 1'b0; tick();
        chk("px_set_mem5", 64'(mem[5]), 64'h8000_0000_0000);
        px_op_do(7'd5, 6'd47, 2'b10, 2, "px_toggle");
        chk("px_toggle_mem5", 64'(mem[5]), 64'd0);
        px_op_do(7'd7, 6'd0, 2'b00, 2, "px_clear");
        chk("px_clear_mem7", 64'(mem[7]), 64'd6);
        px_op_do(7'd7, 6'd2, 2'b11, 2, "px_nop");
        chk("px_nop_mem7", 64'(mem[7]), 64'd6);
        exp_mem[7] = 48'd6;

        // Out-of-range requests: acknowledged, no BRAM access.
        wr0 = n_wr; rd0 = n_rd;
        cw_valid = 1'b1; cw_addr = 7'd90; cw_data = 48'hDEAD; #1;
        chk("oor_cw_ready", 64'({cw_ready, bram_wr_en}), 64'b10);
        tick(); cw_valid = 1'b0;
        px_op_do(7'd84, 6'd0, 2'b01, 1, "oor_px_x");
        px_op_do(7'd3, 6'd50, 2'b01, 1, "oor_px_y");
        chk("oor_no_write", 64'(n_wr - wr0), 64'd0);
        chk("oor_no_read", 64'(n_rd - rd0), 64'd0);
        bad = 0;
        for (int i = 0; i < NC; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk("oor_mem_intact", 64'(bad), 64'd0);

        // Column write and pixel op contending for 10 cycles.
        cw_n = 0; px_n = 0;
        cw_valid = 1'b1; cw_addr = 7'd10; cw_data = 48'hABC;
        px_valid = 1'b1; px_x = 7'd11; px_y = 6'd0; px_op = 2'b01; #1;
        chk("contend_first_cw", 64'(cw_ready), 64'd1);
        for (int i = 0; i < 10; i++) begin
            if (cw_ready) cw_n++;
            if (px_ready) px_n++;
            tick();
        end
`ifdef FRAMEBUFFER_SCHED_RR_EN
        chk("contend_cw_grants", 64'(cw_n), 64'd3);
        chk("contend_px_ready", 64'(px_n), 64'd2);
`else
        chk("contend_cw_grants", 64'(cw_n), 64'd10);
        chk("contend_px_ready", 64'(px_n), 64'd0);
`endif
        cw_valid = 1'b0;
        wait_px(6, cyc, ok);
        chk("contend_px_drain", 64'(ok), 64'd1);
        px_valid = 1'b0; tick();
        exp_mem[10] = 48'hABC;
        chk("contend_mem10", 64'(mem[10]), 64'hABC);

        // Refresh stalled by the driver; pixel ops still proceed.
        col_ready = 1'b0;
        push_frame();
        rd0 = n_rd;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("stall_col_valid", 64'({col_valid, col_data}), 64'({1'b1, 48'h0}));
        px_op_do(7'd0, 6'd3, 2'b01, 2, "stall_px");
        exp_mem[0] = 48'h8;
        for (int i = 0; i < 12; i++) tick();
        chk("stall_col_stable", 64'({col_valid, col_data}), 64'({1'b1, 48'h0}));
        chk("stall_read_count", 64'(n_rd - rd0), 64'd2);
        chk("stall_mem0", 64'(mem[0]), 64'h8);
        col_ready = 1'b1;
        run_frame("f2");
        chk("f2_done_count", 64'(n_done), 64'd2);

        // Reset while the RMW waits for its read data.
        wr0 = n_wr;
        px_valid = 1'b1; px_x = 7'd30; px_y = 6'd0; px_op = 2'b01;
        tick();
        reset = 1'b1; px_valid = 1'b0;
        tick();
        chk("mid_rst_outputs", 64'({col_valid, frame_busy, frame_done, cw_ready, px_ready,
                                    bram_rd_en, bram_wr_en}), 64'd0);
        chk("mid_rst_wdata", 64'({bram_rd_addr, bram_wr_addr, bram_wdata}), 64'd0);
        reset = 1'b0; tick(); tick();
        chk("mid_rst_no_write", 64'(n_wr - wr0), 64'd0);
        chk("mid_rst_mem30", 64'(mem[30]), 64'd30);
        push_frame();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        run_frame("f3");
        chk("f3_done_count", 64'(n_done), 64'd3);
        chk("f3_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/framebuffer_sched.md
Name: framebuffer_sched

Overview:
- Controller and arbiter for the 84-column x 48-bit LCD framebuffer BRAM. This BRAM has one read port and one write port, a 1-cycle read latency, and a valid_out strobe.
- Shares the BRAM between three requesters:
  - the display refresh streamer, which feeds 48-bit columns to the Nokia 5110 SPI driver;
  - a host whole-column write port;
  - a host single-pixel read-modify-write (RMW) port.
- Sits between the drawing logic / LCD driver and the framebuffer BRAM instance.

Parameters:
- NUM_COLS, 84, number of framebuffer columns (BRAM depth).
- COL_BITS, 48, bits per column (display rows).
- ADDR_W, 7, column address width.
- Y_W, 6, pixel row index width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  pulse: begin streaming columns 0..NUM_COLS-1.
- frame_busy  out  1  refresh in progress.
- frame_done  out  1  1-cycle pulse after last column is loaded into col_data.
- col_data  out  COL_BITS  current column to LCD driver.
- col_valid  out  1  col_data holds an unconsumed column.
- col_ready  in  1  LCD driver consumes col_data when col_valid & col_ready.
- cw_valid  in  1  host column write request.
- cw_addr  in  ADDR_W  column index.
- cw_data  in  COL_BITS  column contents.
- cw_ready  out  1  1-cycle grant; the write is issued this cycle.
- px_valid  in  1  host pixel op request; px_* held stable until px_ready.
- px_x  in  ADDR_W  column.
- px_y  in  Y_W  row (bit index, bit 0 = top row).
- px_op  in  2  00 clear, 01 set, 10 toggle, 11 no-op write-back.
- px_ready  out  1  1-cycle completion pulse.
- bram_rd_en, bram_wr_en  out  1  to BRAM.
- bram_rd_addr, bram_wr_addr  out  ADDR_W  to BRAM.
- bram_wdata  out  COL_BITS  to BRAM data_in.
- bram_rdata  in  COL_BITS  from BRAM data_out.
- bram_rvalid  in  1  from BRAM valid_out.

Behaviour:
- Reset values (all outputs 0 after reset): col_valid, col_data, frame_busy, frame_done, cw_ready, px_ready, all bram_* outputs. Internal ref_col = 0; state = IDLE.
- BRAM control outputs are combinational decodes of state and latched fields. They are 0 when unused.
- frame_start with frame_busy=0 sets frame_busy and ref_col=0 on the next edge. frame_start while busy is ignored.
- Grant priority in IDLE, evaluated each cycle:
  1. Refresh: frame_busy & col_valid=0.
  2. Column write: cw_valid.
  3. Pixel op: px_valid.
- IDLE, refresh grant: bram_rd_en=1, rd_addr=ref_col -> REF_WAIT.
- REF_WAIT: on bram_rvalid, latch col_data, set col_valid, ref_col++.
  - If ref_col was NUM_COLS-1: clear frame_busy, pulse frame_done.
  - Then -> IDLE.
- IDLE, column-write grant: bram_wr_en=1, wr_addr=cw_addr, wdata=cw_data, cw_ready=1 in the same cycle. Stay in IDLE; one write per cycle is possible.
- IDLE, pixel grant: latch px_*, bram_rd_en=1, rd_addr=px_x -> PX_WAIT.
- PX_WAIT: on bram_rvalid, latch the modified column: bit px_y cleared/set/inverted/unchanged per px_op -> PX_WR.
- PX_WR: bram_wr_en=1, wr_addr=px_x, px_ready=1 -> IDLE.
  - The RMW is atomic: no other grant is made between its read and its write.
- Latency:
  - Pixel op: px_ready occurs 2 cycles after grant; the op occupies 3 cycles.
  - Refresh column: col_valid rises 2 cycles after the read is issued.
- col_valid clears on col_valid & col_ready. The next refresh read is granted only once col_valid=0, so there is no overlap.
- Out-of-range requests are acknowledged without any BRAM access:
  - cw_addr >= NUM_COLS: cw_ready pulses in IDLE.
  - px_x >= NUM_COLS or px_y >= COL_BITS: px_ready pulses the cycle after grant, state returns to IDLE.
- bram_rvalid outside REF_WAIT/PX_WAIT is ignored.
- A column write and a refresh read of the same column never share a cycle, because only one grant is made per cycle.
- Reset mid-operation: abort refresh and RMW (no write issued), drop col_valid, ignore any late bram_rvalid.

Optional Feature:
- Macro: FRAMEBUFFER_SCHED_RR_EN.
- Defined: column-write and pixel requesters are round-robin arbitrated below refresh.
  - A last_grant bit selects whichever requester was not last served when both are valid.
  - last_grant resets to pixel, so column write wins the first tie.
- Undefined: fixed priority, column write over pixel. A continuously valid cw_valid may starve pixel ops.

Test Plan:
- Reset, then frame_start with col_ready tied 1 and the BRAM preloaded with col n = n -> col_data sequence 0..83, each col_valid 2 cycles after its read; frame_done pulses once after col 83; frame_busy falls.
- Col 5 = 0; px_op=01, px_x=5, px_y=47 -> px_ready 2 cycles after grant; col 5 = 0x8000_0000_0000. Then px_op=10, same coordinates -> col 5 = 0.
- cw_valid with cw_addr=90, and separately px_x=84 -> ready pulses occur; bram_wr_en never asserted; BRAM contents unchanged.
- cw_valid and px_valid held together 10 cycles:
  - without macro, 10 cw grants and no px_ready;
  - with FRAMEBUFFER_SCHED_RR_EN, column writes and pixel ops alternate, first grant to column write.
- Refresh active with col_ready held 0 for 20 cycles -> exactly one column read; col_data stable; pixel ops still complete meanwhile.
- Reset asserted in PX_WAIT -> no BRAM write; all outputs 0 next cycle; a following frame_start streams from col 0.
